led_glow_ctrl: RTL and testbench

Multi-channel LED brightness controller that sequences intensity ramps and breathing cycles for `NCH` LED outputs. Each channel has a first-order sigma-delta PWM stage and a per-channel ramp engine. Software or a top-level FSM issues per-channel commands over a valid/ready port. The block sits between the board-level control logic and the LED pins, replacing free-running glow counters with commanded behaviour.

---
 rtl/led_glow_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_led_glow_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_glow_ctrl.sv
// rtl/led_glow_ctrl.sv - multi-channel LED ramp/breathe controller with sigma-delta PWM
// Optional gamma duty mapping (one extra register of led latency): define LED_GLOW_GAMMA_EN.
module led_glow_ctrl #(
  parameter int NCH = 4,
  parameter int IW  = 4,
  parameter int RW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [$clog2(NCH)-1:0] cmd_ch,
  input  logic [1:0]             cmd_mode,
  input  logic [IW-1:0]          cmd_target,
  input  logic [RW-1:0]          cmd_rate,
  output logic                   cmd_err,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         led
);
  localparam int CW = $clog2(NCH);

  localparam logic [1:0] OP_SET     = 2'b00;
  localparam logic [1:0] OP_RAMP    = 2'b01;
  localparam logic [1:0] OP_BREATHE = 2'b10;

  typedef enum logic [1:0] {
    M_IDLE    = 2'd0,
    M_RAMP    = 2'd1,
    M_BREATHE = 2'd2
  } mode_t;

  // one-entry command register; cmd_ready is low while it holds a command
  logic          pend;
  logic [CW-1:0] p_ch;
  logic [1:0]    p_mode;
  logic [IW-1:0] p_target;
  logic [RW-1:0] p_rate;
  logic          p_oob;

  logic [IW-1:0] level  [NCH];
  logic [IW-1:0] target [NCH];
  mode_t         mode   [NCH];
  logic [RW-1:0] rate   [NCH];
  logic [RW-1:0] rcnt   [NCH];
  logic          dir    [NCH];
  logic [IW:0]   acc    [NCH];
  logic [IW-1:0] duty   [NCH];

  logic [IW-1:0] level_nxt  [NCH];
  logic [IW-1:0] target_nxt [NCH];
  mode_t         mode_nxt   [NCH];
  logic [RW-1:0] rate_nxt   [NCH];
  logic [RW-1:0] rcnt_nxt   [NCH];
  logic          dir_nxt    [NCH];

  logic [IW-1:0] nl;
  logic          go_up;

  assign cmd_ready = ~pend;
  assign p_oob     = ({1'b0, p_ch} >= (CW+1)'(NCH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      p_ch     <= '0;
      p_mode   <= '0;
      p_target <= '0;
      p_rate   <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= pend & p_oob;
      if (pend) begin
        pend <= 1'b0;
      end else if (cmd_valid) begin
        pend     <= 1'b1;
        p_ch     <= cmd_ch;
        p_mode   <= cmd_mode;
        p_target <= cmd_target;
        p_rate   <= cmd_rate;
      end
    end
  end

  always_comb begin
    nl    = '0;
    go_up = 1'b0;
    busy  = '0;
    led   = '0;
    for (int i = 0; i < NCH; i++) begin
      level_nxt[i]  = level[i];
      target_nxt[i] = target[i];
      mode_nxt[i]   = mode[i];
      rate_nxt[i]   = rate[i];
      rcnt_nxt[i]   = rcnt[i];
      dir_nxt[i]    = dir[i];
      busy[i]       = (mode[i] != M_IDLE);
      led[i]        = acc[i][IW];
      // an applied command overrides any step due on the same edge
      if (pend && (p_ch == CW'(i))) begin
        rcnt_nxt[i] = '0;
        case (p_mode)
          OP_SET: begin
            level_nxt[i]  = p_target;
            target_nxt[i] = p_target;
            mode_nxt[i]   = M_IDLE;
          end
          OP_RAMP: begin
            target_nxt[i] = p_target;
            rate_nxt[i]   = p_rate;
            mode_nxt[i]   = (level[i] == p_target) ? M_IDLE : M_RAMP;
          end
          OP_BREATHE: begin
            target_nxt[i] = p_target;
            rate_nxt[i]   = p_rate;
            dir_nxt[i]    = (level[i] < p_target);
            mode_nxt[i]   = M_BREATHE;
          end
          default: begin
            level_nxt[i] = '0;
            mode_nxt[i]  = M_IDLE;
          end
        endcase
      end else if (mode[i] != M_IDLE) begin
        if (rcnt[i] == rate[i]) begin
          rcnt_nxt[i] = '0;
          if (mode[i] == M_RAMP) begin
            if (level[i] < target[i])
              nl = level[i] + 1'b1;
            else if (level[i] > target[i])
              nl = level[i] - 1'b1;
            else
              nl = level[i];
            level_nxt[i] = nl;
            if (nl == target[i])
              mode_nxt[i] = M_IDLE;
          end else begin
            // reverse at the peak going up and at zero going down
            go_up = dir[i] ? (level[i] < target[i]) : (level[i] == '0);
            if (go_up && (level[i] < target[i])) begin
              level_nxt[i] = level[i] + 1'b1;
              dir_nxt[i]   = 1'b1;
            end else if (!go_up && (level[i] != '0)) begin
              level_nxt[i] = level[i] - 1'b1;
              dir_nxt[i]   = 1'b0;
            end
          end
        end else begin
          rcnt_nxt[i] = rcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        level[i]  <= '0;
        target[i] <= '0;
        mode[i]   <= M_IDLE;
        rate[i]   <= '0;
        rcnt[i]   <= '0;
        dir[i]    <= 1'b0;
        acc[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        level[i]  <= level_nxt[i];
        target[i] <= target_nxt[i];
        mode[i]   <= mode_nxt[i];
        rate[i]   <= rate_nxt[i];
        rcnt[i]   <= rcnt_nxt[i];
        dir[i]    <= dir_nxt[i];
        acc[i]    <= {1'b0, acc[i][IW-1:0]} + {1'b0, duty[i]};
      end
    end
  end

`ifdef LED_GLOW_GAMMA_EN
  // (level^2 + level) >> IW keeps 0 and full scale fixed
  logic [2*IW:0] sq [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++)
      sq[i] = (2*IW+1)'(level[i]) * (2*IW+1)'(level[i]) + (2*IW+1)'(level[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++)
        duty[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        duty[i] <= IW'(sq[i] >> IW);
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NCH; i++)
      duty[i] = level[i];
  end
`endif

endmodule

// File: tb/tb_led_glow_ctrl.sv
// tb/tb_led_glow_ctrl.sv - directed self-checking bench for led_glow_ctrl
module tb_led_glow_ctrl;
  localparam int IW = 4;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_ch = '0;
  logic [1:0]    cmd_mode = '0;
  logic [IW-1:0] cmd_target = '0;
  logic [RW-1:0] cmd_rate = '0;
  logic          cmd_err;
  logic [3:0]    busy;
  logic [3:0]    led;

  logic          c3_valid = 1'b0;
  logic          c3_ready;
  logic [1:0]    c3_ch = '0;
  logic [1:0]    c3_mode = '0;
  logic [IW-1:0] c3_target = '0;
  logic [RW-1:0] c3_rate = '0;
  logic          c3_err;
  logic [2:0]    c3_busy;
  logic [2:0]    c3_led;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_glow_ctrl #(.NCH(4), .IW(IW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_target(cmd_target),
    .cmd_rate(cmd_rate), .cmd_err(cmd_err), .busy(busy), .led(led)
  );

  // three channels leave channel code 3 unused, which exercises the range error
  led_glow_ctrl #(.NCH(3), .IW(IW), .RW(RW)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_ch(c3_ch), .cmd_mode(c3_mode), .cmd_target(c3_target),
    .cmd_rate(c3_rate), .cmd_err(c3_err), .busy(c3_busy), .led(c3_led)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] ch, input logic [1:0] md,
                       input logic [IW-1:0] tg, input logic [RW-1:0] rt);
    cmd_ch     = ch;
    cmd_mode   = md;
    cmd_target = tg;
    cmd_rate   = rt;
    cmd_valid  = 1'b1;
    step(1);
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    tests++;
    if ({cmd_ready, cmd_err, busy, led} !== {1'b1, 1'b0, 4'h0, 4'h0}) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b err=%b busy=%h led=%h required 1 0 0 0",
               cmd_ready, cmd_err, busy, led);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_set;
    int cnt;
    logic [3:0] other;
    int exp_cnt;
`ifdef LED_GLOW_GAMMA_EN
    exp_cnt = 4;
`else
    exp_cnt = 8;
`endif
    issue(2'd1, 2'b00, 4'd8, 16'd0);
    step(1);
    tests++;
    if (dut.level[1] !== 4'd8 || busy !== 4'h0) begin
      fails++;
      $display("FAIL set_apply: level1=%0d busy=%h required 8 0", dut.level[1], busy);
    end
    tests++;
    if (led !== 4'h0) begin
      fails++;
      $display("FAIL set_led_latency: led=%h required 0", led);
    end
    step(2);
    cnt = 0;
    other = '0;
    for (int j = 0; j < 16; j++) begin
      cnt += int'(led[1]);
      other |= led & 4'b1101;
      step(1);
    end
    tests++;
    if (cnt !== exp_cnt) begin
      fails++;
      $display("FAIL set_pwm_count: high=%0d required %0d", cnt, exp_cnt);
    end
    tests++;
    if (other !== 4'h0) begin
      fails++;
      $display("FAIL set_other_leds: seen=%h required 0", other);
    end
  endtask

  task automatic test_ramp;
    int exp_lvl;
    logic exp_busy;
    issue(2'd0, 2'b01, 4'd5, 16'd3);
    for (int n = 0; n <= 23; n++) begin
      exp_lvl  = (n < 5) ? 0 : (((n - 1) / 4 > 5) ? 5 : (n - 1) / 4);
      exp_busy = (n >= 1) && (n < 21);
      tests++;
      if (dut.level[0] !== 4'(exp_lvl) || busy[0] !== exp_busy) begin
        fails++;
        $display("FAIL ramp_k+%0d: level=%0d busy=%b required %0d %b",
                 n, dut.level[0], busy[0], exp_lvl, exp_busy);
      end
      step(1);
    end
  endtask

  task automatic test_breathe;
    int tbl [6];
    int exp_lvl;
    tbl = '{1, 2, 3, 2, 1, 0};
    issue(2'd2, 2'b10, 4'd3, 16'd0);
    for (int n = 0; n <= 14; n++) begin
      exp_lvl = (n < 2) ? 0 : tbl[(n - 2) % 6];
      tests++;
      if (dut.level[2] !== 4'(exp_lvl) || busy[2] !== (n >= 1)) begin
        fails++;
        $display("FAIL breathe_k+%0d: level=%0d busy=%b required %0d %b",
                 n, dut.level[2], busy[2], exp_lvl, (n >= 1));
      end
      step(1);
    end
    issue(2'd2, 2'b11, 4'd0, 16'd0);
    step(1);
    tests++;
    if (dut.level[2] !== 4'd0 || busy !== 4'h0 || dut.level[0] !== 4'd5) begin
      fails++;
      $display("FAIL breathe_off: level2=%0d busy=%h level0=%0d required 0 0 5",
               dut.level[2], busy, dut.level[0]);
    end
  endtask

  task automatic test_pwm;
    int lv [2];
    int exp_cnt;
    int cnt;
    lv = '{15, 5};
    for (int t = 0; t < 2; t++) begin
`ifdef LED_GLOW_GAMMA_EN
      exp_cnt = (lv[t] * lv[t] + lv[t]) >> IW;
`else
      exp_cnt = lv[t];
`endif
      issue(2'd3, 2'b00, 4'(lv[t]), 16'd0);
      step(3);
      cnt = 0;
      for (int j = 0; j < 16; j++) begin
        cnt += int'(led[3]);
        step(1);
      end
      tests++;
      if (cnt !== exp_cnt) begin
        fails++;
        $display("FAIL pwm_level%0d: high=%0d required %0d", lv[t], cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [IW-1:0] tg [4];
    int idx;
    logic rdy;
    tg = '{4'd2, 4'd4, 4'd6, 4'd9};
    idx = 0;
    for (int j = 0; j < 8; j++) begin
      cmd_valid = (idx < 4);
      if (idx < 4) begin
        cmd_ch     = 2'(idx);
        cmd_mode   = 2'b00;
        cmd_target = tg[idx];
        cmd_rate   = '0;
      end
      tests++;
      if (cmd_ready !== ((j % 2) == 0)) begin
        fails++;
        $display("FAIL b2b_ready_%0d: cmd_ready=%b required %b", j, cmd_ready, ((j % 2) == 0));
      end
      rdy = cmd_ready;
      step(1);
      if (rdy && cmd_valid) idx++;
    end
    cmd_valid = 1'b0;
    tests++;
    if (idx !== 4) begin
      fails++;
      $display("FAIL b2b_accepted: count=%0d required 4", idx);
    end
    tests++;
    if ({dut.level[0], dut.level[1], dut.level[2], dut.level[3]} !== {4'd2, 4'd4, 4'd6, 4'd9}) begin
      fails++;
      $display("FAIL b2b_levels: %0d %0d %0d %0d required 2 4 6 9",
               dut.level[0], dut.level[1], dut.level[2], dut.level[3]);
    end
  endtask

  task automatic test_cmd_err;
    c3_ch = 2'd1; c3_mode = 2'b00; c3_target = 4'd7; c3_rate = '0; c3_valid = 1'b1;
    step(1);
    c3_valid = 1'b0;
    step(1);
    c3_ch = 2'd3; c3_mode = 2'b00; c3_target = 4'd15; c3_valid = 1'b1;
    step(1);
    c3_valid = 1'b0;
    tests++;
    if (c3_err !== 1'b0) begin
      fails++;
      $display("FAIL err_at_accept: cmd_err=%b required 0", c3_err);
    end
    step(1);
    tests++;
    if (c3_err !== 1'b1) begin
      fails++;
      $display("FAIL err_pulse: cmd_err=%b required 1", c3_err);
    end
    step(1);
    tests++;
    if (c3_err !== 1'b0) begin
      fails++;
      $display("FAIL err_one_cycle: cmd_err=%b required 0", c3_err);
    end
    tests++;
    if ({dut3.level[0], dut3.level[1], dut3.level[2]} !== {4'd0, 4'd7, 4'd0} ||
        c3_busy !== 3'b000 || c3_ready !== 1'b1) begin
      fails++;
      $display("FAIL err_no_change: levels=%0d %0d %0d busy=%b ready=%b required 0 7 0 000 1",
               dut3.level[0], dut3.level[1], dut3.level[2], c3_busy, c3_ready);
    end
    tests++;
    if (cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL err_inrange_quiet: cmd_err=%b required 0", cmd_err);
    end
  endtask

  task automatic test_reset_mid;
    issue(2'd3, 2'b01, 4'd0, 16'd2);
    step(4);
    tests++;
    if (busy[3] !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_busy: busy3=%b required 1", busy[3]);
    end
    cmd_ch = 2'd1; cmd_mode = 2'b00; cmd_target = 4'd15; cmd_rate = '0; cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_pending: cmd_ready=%b required 0", cmd_ready);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({cmd_ready, cmd_err, busy, led} !== {1'b1, 1'b0, 4'h0, 4'h0}) begin
      fails++;
      $display("FAIL rstmid_async: ready=%b err=%b busy=%h led=%h required 1 0 0 0",
               cmd_ready, cmd_err, busy, led);
    end
    step(1);
    rst = 1'b0;
    step(3);
    tests++;
    if ({dut.level[0], dut.level[1], dut.level[2], dut.level[3]} !== 16'h0 ||
        busy !== 4'h0 || led !== 4'h0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_no_stale: levels=%0d %0d %0d %0d busy=%h led=%h ready=%b required 0 0 0 0 0 0 1",
               dut.level[0], dut.level[1], dut.level[2], dut.level[3], busy, led, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_ramp();
    test_breathe();
    test_pwm();
    test_back_to_back();
    test_cmd_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
